ice_pin_pattern_gen: RTL and testbench

//   Drives the iCE40 user I/O pins with a walking-ones then walking-zeros pattern so the
//   RP2040 side of the test jig can read each pin and detect opens and shorts.

---
 rtl/ice_pin_pattern_gen.sv | 111 +++++++++++
 tb/tb_ice_pin_pattern_gen.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ice_pin_pattern_gen.sv
// Walking-ones / walking-zeros pin pattern generator for the iCE40 test jig.
// Advances on a synchronized rising edge of step_async or after a fixed dwell in auto mode.
module ice_pin_pattern_gen #(
  parameter int NUM_PINS     = 32,
  parameter int DWELL_CYCLES = 12_000_000,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        step_async,
  input  logic                        auto_en,
  output logic [NUM_PINS-1:0]         pins_out,
  output logic [NUM_PINS-1:0]         pins_oe,
  output logic [$clog2(NUM_PINS)-1:0] index,
  output logic [1:0]                  phase,
  output logic                        led_r,
  output logic                        led_g,
  output logic                        led_b
);
  localparam int IW = $clog2(NUM_PINS);
  localparam int CW = $clog2(DWELL_CYCLES);
  localparam logic [NUM_PINS-1:0] ONE = NUM_PINS'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, WALK1 = 2'd1, WALK0 = 2'd2, DONE = 2'd3} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   step_prev;
  logic                   step_rise;
  logic [CW-1:0]          dwell;
  logic                   dwell_hit;
  logic                   adv;
  logic                   last;

  // Synchronizer and edge history reset high so a step held through reset is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '1;
      step_prev <= 1'b1;
      step_rise <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], step_async};
      step_prev <= sync_q[SYNC_STAGES-1];
      step_rise <= sync_q[SYNC_STAGES-1] & ~step_prev;
    end
  end

  assign dwell_hit = auto_en && (state != DONE) && (dwell == CW'(DWELL_CYCLES - 1));
  assign adv       = step_rise | dwell_hit;
  assign last      = (index == IW'(NUM_PINS - 1));
  assign phase     = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                dwell <= '0;
    else if (!auto_en || adv)  dwell <= '0;
    else if (state != DONE)    dwell <= dwell + CW'(1);
  end

  // Outputs are assigned alongside each transition so they stay pure flop outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      index    <= '0;
      pins_out <= '0;
      pins_oe  <= '0;
      led_r    <= 1'b1;
      led_g    <= 1'b1;
      led_b    <= 1'b1;
    end else if (adv) begin
      case (state)
        IDLE: begin
          state    <= WALK1;
          index    <= '0;
          pins_oe  <= '1;
          pins_out <= ONE;
          led_b    <= 1'b0;
        end
        WALK1: begin
          if (last) begin
            state    <= WALK0;
            index    <= '0;
            pins_out <= ~ONE;
            led_b    <= 1'b1;
            led_r    <= 1'b0;
          end else begin
            index    <= index + IW'(1);
            pins_out <= pins_out << 1;
          end
        end
        WALK0: begin
          if (last) begin
            state    <= DONE;
            index    <= '0;
            pins_oe  <= '0;
            pins_out <= '0;
            led_r    <= 1'b1;
            led_g    <= 1'b0;
          end else begin
            index    <= index + IW'(1);
            pins_out <= {pins_out[NUM_PINS-2:0], 1'b1};
          end
        end
        default: begin
          state <= IDLE;
          index <= '0;
          led_g <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ice_pin_pattern_gen.sv
// Scoreboard bench: stimulus predicts each pattern step (position + cycle), a monitor
// pops and compares whenever the DUT outputs change.
module tb_ice_pin_pattern_gen;
  localparam int N     = 4;
  localparam int DWELL = 5;
  localparam int NPOS  = 2 * N + 2;  // IDLE, N walk-1 steps, N walk-0 steps, DONE

  logic         clk = 1'b0;
  logic         rst_n;
  logic         step_async;
  logic         auto_en;
  logic [N-1:0] pins_out, pins_oe;
  logic [1:0]   index;
  logic [1:0]   phase;
  logic         led_r, led_g, led_b;

  ice_pin_pattern_gen #(.NUM_PINS(N), .DWELL_CYCLES(DWELL), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .step_async(step_async), .auto_en(auto_en),
    .pins_out(pins_out), .pins_oe(pins_oe), .index(index), .phase(phase),
    .led_r(led_r), .led_g(led_g), .led_b(led_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; int p; } exp_t;
  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   pos    = 0;

  // Expected {oe, out, phase, index, r, g, b} for a position in the overall sequence.
  function automatic logic [14:0] model(input int p);
    logic [N-1:0] bit1;
    int           i;
    if (p == 0) return {4'b0, 4'b0, 2'd0, 2'd0, 3'b111};
    if (p <= N) begin
      i = p - 1;
      bit1 = N'(1) << i;
      return {4'hF, bit1, 2'd1, 2'(i), 3'b110};
    end
    if (p <= 2 * N) begin
      i = p - 1 - N;
      bit1 = N'(1) << i;
      return {4'hF, ~bit1, 2'd2, 2'(i), 3'b011};
    end
    return {4'b0, 4'b0, 2'd3, 2'd0, 3'b101};
  endfunction

  function automatic logic [14:0] snap();
    return {pins_oe, pins_out, phase, index, led_r, led_g, led_b};
  endfunction

  // Monitor: any output change must match the head of the scoreboard at the predicted cycle.
  initial begin
    logic [14:0] prev, cur;
    exp_t        e;
    prev = 'x;
    forever begin
      @(negedge clk);
      cur = snap();
      if (!rst_n) prev = cur;
      else if (cur !== prev) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cyc=%0d got=%h", cyc, cur);
        end else begin
          e = q.pop_front();
          if (cur !== model(e.p) || cyc != e.c) begin
            errors++;
            $display("FAIL step pos=%0d got=%h@%0d want=%h@%0d", e.p, cur, cyc, model(e.p), e.c);
          end
        end
        prev = cur;
      end else if (q.size() > 0 && cyc > q[0].c) begin
        checks++;
        errors++;
        e = q.pop_front();
        $display("FAIL missed_step pos=%0d want_cyc=%0d got=%h", e.p, e.c, cur);
      end
    end
  end

  task automatic check_now(input string name, input logic [14:0] want);
    checks++;
    if (snap() !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, snap(), want);
    end
  endtask

  // Manual step: change expected 4 edge-counts after the drive point (3 edges after the rise).
  task automatic pulse();
    int hi, lo;
    hi = $urandom_range(7, 4);
    lo = $urandom_range(8, 4);
    @(negedge clk);
    step_async = 1'b1;
    pos = (pos + 1) % NPOS;
    q.push_back('{cyc + 4, pos});
    repeat (hi) @(negedge clk);
    step_async = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    pos = 0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int c0;
    rst_n = 1'b0; step_async = 1'b0; auto_en = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_now("reset_state", model(0));
    repeat (100) @(negedge clk);
    check_now("idle_hold", model(0));

    // Eleven manual pulses across the full sequence and back into WALK1.
    repeat (11) pulse();
    do_reset();

    // Auto mode from IDLE to DONE, then hold in DONE.
    @(negedge clk);
    auto_en = 1'b1;
    c0 = cyc;
    for (int k = 1; k < NPOS; k++) q.push_back('{c0 + DWELL * k, k});
    pos = NPOS - 1;
    while (cyc < c0 + DWELL * (NPOS - 1) + 50) @(negedge clk);
    check_now("done_hold", model(NPOS - 1));
    auto_en = 1'b0;
    @(negedge clk);
    pulse();

    // Step edge coincides with dwell expiry: one advance, then dwell restarts.
    @(negedge clk);
    auto_en = 1'b1;
    c0 = cyc;
    @(negedge clk);
    step_async = 1'b1;
    for (int k = 1; k <= 3; k++) q.push_back('{c0 + DWELL * k, k});
    pos = 3;
    repeat (4) @(negedge clk);
    step_async = 1'b0;
    while (cyc < c0 + 3 * DWELL + 2) @(negedge clk);
    auto_en = 1'b0;
    repeat (6) @(negedge clk);

    // Walk into WALK0 index 2, then reset between clock edges.
    while (pos != N + 3) pulse();
    @(negedge clk);
    check_now("walk0_idx2", model(N + 3));
    #2 rst_n = 1'b0;
    #1 check_now("async_reset", model(0));
    pos = 0;

    // Step held high through reset release must not advance.
    step_async = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_now("step_high_release", model(0));
    step_async = 1'b0;
    repeat (4) @(negedge clk);
    repeat (6) pulse();

    for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
